// File: rtl/reg_file_read_port.sv
// reg_file_read_port: register file with two combinational read ports, per-register
// pending-write counters and RAW stall generation. Optional macro: REG_FILE_BYPASS_EN.
`default_nettype none

module reg_file_read_port #(
  parameter int DATA_W   = 24,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              rd_en_a,
  input  logic              rd_en_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              stall
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [PEND_W-1:0]   pend [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic                hit_a;
  logic                hit_b;
  logic                hz_a;
  logic                hz_b;

  assign issue_ready = rst | (pend[issue_dst] != PEND_MAX);

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r] = issue_en & issue_ready & (issue_dst == ADDR_W'(r));
      dec[r] = wr_en & (wr_addr == ADDR_W'(r)) & (pend[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_en && (wr_addr == ADDR_W'(r)))
          regs[r] <= wr_data;
        // Simultaneous issue and retire cancel out; the counter stays put.
        if (inc[r] && !dec[r])
          pend[r] <= pend[r] + PEND_W'(1);
        else if (dec[r] && !inc[r])
          pend[r] <= pend[r] - PEND_W'(1);
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  assign hit_a = wr_en & ~rst & (wr_addr == rd_addr_a);
  assign hit_b = wr_en & ~rst & (wr_addr == rd_addr_b);
  assign rd_data_a = rst ? '0 : (hit_a ? wr_data : regs[rd_addr_a]);
  assign rd_data_b = rst ? '0 : (hit_b ? wr_data : regs[rd_addr_b]);
`else
  // Without forwarding, a landing write-back does not retire the hazard this cycle.
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
  assign rd_data_a = rst ? '0 : regs[rd_addr_a];
  assign rd_data_b = rst ? '0 : regs[rd_addr_b];
`endif

  assign hz_a  = rd_en_a & (pend[rd_addr_a] > {{(PEND_W-1){1'b0}}, hit_a});
  assign hz_b  = rd_en_b & (pend[rd_addr_b] > {{(PEND_W-1){1'b0}}, hit_b});
  assign stall = ~rst & (hz_a | hz_b);

endmodule

`default_nettype wire

// File: tb/tb_reg_file_read_port.sv
// tb_reg_file_read_port: directed scenarios plus randomized traffic checked against
// a behavioural model of registers and outstanding-write counts.
`default_nettype none

module tb_reg_file_read_port;
  localparam int DW = 24;
  localparam int NR = 8;
  localparam int AW = 3;
  localparam int MAXP = 3;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          issue_en = 1'b0;
  logic [AW-1:0] issue_dst = '0;
  logic          issue_ready;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic          rd_en_a = 1'b0;
  logic          rd_en_b = 1'b0;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          stall;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  int unsigned m_regs [NR];
  int          m_pend [NR];

  reg_file_read_port dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_dst(issue_dst), .issue_ready(issue_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .stall(stall)
  );

  always #5 clk = ~clk;

  // Model: registers hold last written value; each register counts writes issued but not yet written back.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_regs[r] = 0;
        m_pend[r] = 0;
      end
    end else begin
      int  idst, wdst;
      bit  do_inc, do_dec;
      idst   = int'(issue_dst);
      wdst   = int'(wr_addr);
      do_inc = issue_en && (m_pend[idst] < MAXP);
      do_dec = wr_en && (m_pend[wdst] > 0);
      if (wr_en) m_regs[wdst] = int'(wr_data);
      if (do_dec) m_pend[wdst] = m_pend[wdst] - 1;
      if (do_inc) m_pend[idst] = m_pend[idst] + 1;
    end
  end

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (rst) return '0;
    if (BYP && wr_en && wr_addr == a) return wr_data;
    return DW'(m_regs[int'(a)]);
  endfunction

  function automatic logic exp_hz(input logic en, input logic [AW-1:0] a);
    int left;
    if (rst || !en) return 1'b0;
    left = m_pend[int'(a)];
    if (BYP && wr_en && wr_addr == a && left > 0) left = left - 1;
    return left > 0;
  endfunction

  function automatic logic exp_ready();
    if (rst) return 1'b1;
    return m_pend[int'(issue_dst)] < MAXP;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model rd_data_a", rd_data_a, exp_data(rd_addr_a));
      chk("model rd_data_b", rd_data_b, exp_data(rd_addr_b));
      chk("model stall", DW'(stall), DW'(exp_hz(rd_en_a, rd_addr_a) | exp_hz(rd_en_b, rd_addr_b)));
      chk("model issue_ready", DW'(issue_ready), DW'(exp_ready()));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; issue_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
  endtask

  task automatic iss(input int a);
    issue_en = 1'b1; issue_dst = AW'(a);
  endtask

  initial begin
    repeat (2) next();
    chk("reset rd_data_a", rd_data_a, '0);
    chk("reset stall", DW'(stall), '0);
    chk("reset issue_ready", DW'(issue_ready), 1);
    rst = 1'b0;
    chk_on = 1'b1;

    // Mid-run reset with data and a pending write present.
    wr(2, 24'h555555); iss(5); next();
    idle(); next();
    rst = 1'b1; rd_en_a = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd2; issue_dst = 3'd5;
    #1;
    chk("midrst rd_data_b", rd_data_b, '0);
    chk("midrst stall", DW'(stall), '0);
    chk("midrst issue_ready", DW'(issue_ready), 1);
    next();
    rst = 1'b0; idle();

    wr(3, 24'h00ABCD); next();
    idle(); rd_addr_a = 3'd3; @(negedge clk);
    chk("r3 readback", rd_data_a, 24'h00ABCD);
    next();

    // Bypass on same-cycle write-back.
    wr(5, 24'h111111); next();
    wr(5, 24'h123456); rd_addr_a = 3'd5; @(negedge clk);
    chk("bypass same cycle", rd_data_a, BYP ? 24'h123456 : 24'h111111);
    next();
    idle(); @(negedge clk);
    chk("bypass next cycle", rd_data_a, 24'h123456);
    next();

    // RAW stall on r2.
    iss(2); next();
    idle(); rd_en_b = 1'b1; rd_addr_b = 3'd2; @(negedge clk);
    chk("raw stall", DW'(stall), 1);
    next();
    wr(2, 24'h0000A2); @(negedge clk);
    chk("raw wb cycle", DW'(stall), BYP ? 0 : 1);
    next();
    idle(); rd_en_b = 1'b1; @(negedge clk);
    chk("raw cleared", DW'(stall), 0);
    next();

    // Three outstanding writes to r4, fourth issue ignored.
    idle(); iss(4); next(); next(); next();
    @(negedge clk);
    chk("r4 full ready", DW'(issue_ready), 0);
    next();
    idle(); rd_en_a = 1'b1; rd_addr_a = 3'd4; wr(4, 24'h000041); @(negedge clk);
    chk("r4 wb1 stall", DW'(stall), 1);
    next();
    wr(4, 24'h000042); @(negedge clk);
    chk("r4 wb2 stall", DW'(stall), 1);
    next();
    wr(4, 24'h000043); @(negedge clk);
    chk("r4 wb3 stall", DW'(stall), BYP ? 0 : 1);
    next();
    wr_en = 1'b0; issue_dst = 3'd4; @(negedge clk);
    chk("r4 drained stall", DW'(stall), 0);
    chk("r4 drained ready", DW'(issue_ready), 1);
    next();

    // Issue and write-back to r6 on the same edge keep the count at one.
    idle(); iss(6); next();
    wr(6, 24'h000066); rd_en_a = 1'b1; rd_addr_a = 3'd6; next();
    idle(); rd_en_a = 1'b1; @(negedge clk);
    chk("r6 stall persists", DW'(stall), 1);
    next();
    wr(6, 24'h000067); next();

    // Stray write to an idle register.
    idle(); wr(1, 24'h0F0F0F); next();
    idle(); rd_en_b = 1'b1; rd_addr_b = 3'd1; issue_dst = 3'd1; @(negedge clk);
    chk("stray data", rd_data_b, 24'h0F0F0F);
    chk("stray stall", DW'(stall), 0);
    next();

    // Unused operand must not stall.
    idle(); iss(7); next();
    idle(); rd_addr_a = 3'd7; @(negedge clk);
    chk("unused operand", DW'(stall), 0);
    rd_en_a = 1'b1; #1;
    chk("used operand", DW'(stall), 1);
    next();
    wr(7, 24'h000077); next();
    idle();

    // Randomized traffic, addresses biased toward a few registers to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1; next(); rst = 1'b0;
      end
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = AW'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 3 : 7));
      wr_data   = DW'($urandom);
      issue_en  = ($urandom_range(0, 2) != 0);
      issue_dst = AW'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 3 : 7));
      rd_en_a   = ($urandom_range(0, 3) != 0);
      rd_en_b   = ($urandom_range(0, 3) != 0);
      rd_addr_a = AW'($urandom_range(0, 7));
      rd_addr_b = AW'($urandom_range(0, 3));
      next();
    end
    idle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/reg_file_read_port.md
Name: reg_file_read_port

Overview:
- Register-file storage plus read side of the write-back path.
- Accepts the selected 24-bit write-back word and its destination from the write-back stage.
- Serves two combinational operand reads to decode.
- Tracks in-flight destination writes with per-register pending counters.
- Raises a read-after-write stall to decode when a source operand has an outstanding write.

Parameters:
DATA_W, 24, register and data width
NUM_REGS, 8, number of architectural registers
ADDR_W, 3, register address width; NUM_REGS equals 2**ADDR_W
PEND_W, 2, width of each per-register pending-write counter (max 3 outstanding writes)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write-back valid this cycle
wr_addr  input  ADDR_W  write-back destination register
wr_data  input  DATA_W  write-back data (selected immediate / pc link / mem-stage result)
issue_en  input  1  decode issues an instruction that will write a register
issue_dst  input  ADDR_W  destination of the issued instruction
issue_ready  output  1  issue_dst counter below max; issue accepted only when high
rd_addr_a  input  ADDR_W  source operand A address
rd_addr_b  input  ADDR_W  source operand B address
rd_en_a  input  1  operand A is used by the instruction in decode
rd_en_b  input  1  operand B is used by the instruction in decode
rd_data_a  output  DATA_W  operand A value
rd_data_b  output  DATA_W  operand B value
stall  output  1  decode must hold; operand not yet available

Behaviour:
- Reset (async, rst=1):
  - All registers cleared to 0.
  - All pending counters cleared to 0.
  - Outputs during reset: stall=0, issue_ready=1, rd_data_a/b=0.
  - Reset asserted mid-operation discards all pending state immediately.
  - The first edge after deassertion behaves normally.
- Write:
  - On a rising edge with wr_en=1, regs[wr_addr] <= wr_data.
  - Register 0 is an ordinary writable register.
- Reads: combinational. rd_data_x = regs[rd_addr_x], subject to the bypass rule in Optional Feature.
- Pending counters, per register r, evaluated at each edge:
  - inc = issue_en & issue_ready & (issue_dst==r).
  - dec = wr_en & (wr_addr==r) & (pend[r]!=0).
  - inc only: +1. dec only: -1. Both: unchanged.
  - A write to a register with pend=0 updates data but leaves the counter at 0; no underflow.
- issue_ready = (pend[issue_dst] != max).
  - An issue_en with issue_ready=0 is ignored; the counter does not wrap.
- Hazard for operand x:
  - hz_x = rd_en_x & (pend[rd_addr_x] > k_x).
  - k_x = 1 if wr_en & wr_addr==rd_addr_x this cycle (write-back completes one outstanding write), else 0. This assumes bypass; see Optional Feature.
- stall = hz_a | hz_b, combinational.
  - stall has no effect on the counters; decode is responsible for not issuing while stalled.
- Latency:
  - Written data is visible on the read ports in the same cycle with bypass, or the next cycle without it.
  - Counter changes are visible the cycle after the edge.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - If wr_en and wr_addr==rd_addr_x, rd_data_x = wr_data in the same cycle.
  - A hazard uses k_x as above.
- Undefined:
  - No forwarding; rd_data_x is the stored value.
  - k_x is forced to 0, so a same-cycle write-back to the last pending write still stalls for one cycle.
  - The operand reads correctly the following cycle.

Test Plan:
- Reset / read / write:
  - Assert rst mid-run after writes → all rd_data=0, stall=0, issue_ready=1 immediately.
  - Then write r3=0x00ABCD; read r3 next cycle → 0x00ABCD.
- Bypass:
  - wr_en=1, wr_addr=5, wr_data=0x123456, rd_addr_a=5 in the same cycle.
  - With REG_FILE_BYPASS_EN → rd_data_a=0x123456 that cycle.
  - Without → old value that cycle, 0x123456 next cycle.
- RAW stall:
  - Issue dst=2; next cycle rd_en_b=1, rd_addr_b=2 → stall=1.
  - Write-back r2 arrives → stall=0 that cycle (bypass) or next cycle (no bypass).
- Multiple outstanding writes:
  - Issue dst=4 three times → pend=3, issue_ready=0 for dst=4.
  - A fourth issue is ignored.
  - Three write-backs needed before stall on r4 clears; the first two leave stall=1.
- Simultaneous issue and write:
  - pend[6]=1; issue dst=6 and write-back r6 on the same edge → pend stays 1 and stall on r6 persists.
  - Stray write to r1 with pend=0 → data updated, counter stays 0.
- Unused operand: rd_en_a=0 with rd_addr_a pointing at a pending register → stall=0.
